axil_arbiter_2m: RTL and testbench

- Two-master AXI-Lite arbiter placed in front of the AXI-Lite-to-APB bridge, so two requesters (CPU and DMA) can share the single APB peripheral space.
- Serialises traffic: only one transaction (read or write) is outstanding at the bridge at any time, with round-robin fairness between masters.
- Addresses outside the bridge window get a local DECERR and never reach the bridge.

---
 rtl/axil_arbiter_2m_pkg.sv | 27 ++
 rtl/axil_rr_pick.sv | 27 ++
 rtl/axil_arbiter_2m.sv | 245 ++++++++++++++++++++++++
 tb/tb_axil_arbiter_2m.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_arbiter_2m_pkg.sv
// rtl/axil_arbiter_2m_pkg.sv - shared constants and helpers for the two-master AXI-Lite arbiter
package axil_arbiter_2m_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_WR_ADDR  = 3'd1;
    localparam state_t ST_WR_RESP  = 3'd2;
    localparam state_t ST_RD_ADDR  = 3'd3;
    localparam state_t ST_RD_DATA  = 3'd4;
    localparam state_t ST_ERR_WR   = 3'd5;
    localparam state_t ST_ERR_RESP = 3'd6;

    // True when the upper address half selects the bridge window.
    function automatic logic window_hit(input logic [15:0] addr_hi, input logic [15:0] base_hi);
        return addr_hi == base_hi;
    endfunction

endpackage

// File: rtl/axil_rr_pick.sv
// rtl/axil_rr_pick.sv - two-master round-robin picker with write-over-read priority
module axil_rr_pick (
    input  logic [1:0] wreq_i,
    input  logic [1:0] rreq_i,
    input  logic       rr_ptr_i,
    output logic       gnt_m_o,
    output logic       gnt_wr_o,
    output logic       any_o
);

    logic [1:0] req;

    assign req   = wreq_i | rreq_i;
    assign any_o = |req;

    // Lone requester wins outright; on contention the round-robin pointer decides.
    always_comb begin
        gnt_m_o = 1'b0;
        if (req[0] && req[1]) begin
            gnt_m_o = rr_ptr_i;
        end else if (req[1]) begin
            gnt_m_o = 1'b1;
        end
        gnt_wr_o = wreq_i[gnt_m_o];
    end

endmodule

// File: rtl/axil_arbiter_2m.sv
// rtl/axil_arbiter_2m.sv - two-master AXI-Lite arbiter in front of the AXI-Lite-to-APB bridge
module axil_arbiter_2m
    import axil_arbiter_2m_pkg::*;
#(
    parameter int          ADDR_W  = AXI_ADDR_W,
    parameter int          DATA_W  = AXI_DATA_W,
    parameter logic [15:0] BASE_HI = 16'h4000
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [ADDR_W-1:0] M0_AWADDR,
    input  logic              M0_AWVALID,
    output logic              M0_AWREADY,
    input  logic [DATA_W-1:0] M0_WDATA,
    input  logic              M0_WVALID,
    output logic              M0_WREADY,
    output logic [1:0]        M0_BRESP,
    output logic              M0_BVALID,
    input  logic              M0_BREADY,
    input  logic [ADDR_W-1:0] M0_ARADDR,
    input  logic              M0_ARVALID,
    output logic              M0_ARREADY,
    output logic [DATA_W-1:0] M0_RDATA,
    output logic [1:0]        M0_RRESP,
    output logic              M0_RVALID,
    input  logic              M0_RREADY,
    input  logic [ADDR_W-1:0] M1_AWADDR,
    input  logic              M1_AWVALID,
    output logic              M1_AWREADY,
    input  logic [DATA_W-1:0] M1_WDATA,
    input  logic              M1_WVALID,
    output logic              M1_WREADY,
    output logic [1:0]        M1_BRESP,
    output logic              M1_BVALID,
    input  logic              M1_BREADY,
    input  logic [ADDR_W-1:0] M1_ARADDR,
    input  logic              M1_ARVALID,
    output logic              M1_ARREADY,
    output logic [DATA_W-1:0] M1_RDATA,
    output logic [1:0]        M1_RRESP,
    output logic              M1_RVALID,
    input  logic              M1_RREADY,
    output logic [ADDR_W-1:0] S_AWADDR,
    output logic [2:0]        S_AWPROT,
    output logic              S_AWVALID,
    input  logic              S_AWREADY,
    output logic [DATA_W-1:0] S_WDATA,
    output logic              S_WVALID,
    input  logic              S_WREADY,
    input  logic [1:0]        S_BRESP,
    input  logic              S_BVALID,
    output logic              S_BREADY,
    output logic [ADDR_W-1:0] S_ARADDR,
    output logic [2:0]        S_ARPROT,
    output logic              S_ARVALID,
    input  logic              S_ARREADY,
    input  logic [DATA_W-1:0] S_RDATA,
    input  logic [1:0]        S_RRESP,
    input  logic              S_RVALID,
    output logic              S_RREADY
);

    state_t state_q, state_d;
    logic   rr_ptr_q, rr_ptr_d;
    logic   gnt_m_q, gnt_m_d;
    logic   gnt_wr_q, gnt_wr_d;
    logic   aw_done_q, aw_done_d;
    logic   w_done_q, w_done_d;
    logic   ar_done_q, ar_done_d;

    logic        pick_m, pick_wr, pick_any, pick_hit;
    logic [15:0] pick_hi;

    logic g_awvalid, g_wvalid, g_bready, g_arvalid, g_rready;

    logic              aw_rdy, w_rdy, ar_rdy, b_valid, r_valid;
    logic [1:0]        b_resp, r_resp;
    logic [DATA_W-1:0] r_data;

    axil_rr_pick u_pick (
        .wreq_i   ({M1_AWVALID | M1_WVALID, M0_AWVALID | M0_WVALID}),
        .rreq_i   ({M1_ARVALID, M0_ARVALID}),
        .rr_ptr_i (rr_ptr_q),
        .gnt_m_o  (pick_m),
        .gnt_wr_o (pick_wr),
        .any_o    (pick_any)
    );

    // A write granted on W alone is decoded on whatever AWADDR the master presents alongside it.
    assign pick_hi  = pick_m ? (pick_wr ? M1_AWADDR[31:16] : M1_ARADDR[31:16])
                             : (pick_wr ? M0_AWADDR[31:16] : M0_ARADDR[31:16]);
    assign pick_hit = window_hit(pick_hi, BASE_HI);

    assign g_awvalid = gnt_m_q ? M1_AWVALID : M0_AWVALID;
    assign g_wvalid  = gnt_m_q ? M1_WVALID  : M0_WVALID;
    assign g_bready  = gnt_m_q ? M1_BREADY  : M0_BREADY;
    assign g_arvalid = gnt_m_q ? M1_ARVALID : M0_ARVALID;
    assign g_rready  = gnt_m_q ? M1_RREADY  : M0_RREADY;

    assign S_AWADDR = gnt_m_q ? M1_AWADDR : M0_AWADDR;
    assign S_WDATA  = gnt_m_q ? M1_WDATA  : M0_WDATA;
    assign S_ARADDR = gnt_m_q ? M1_ARADDR : M0_ARADDR;
    assign S_AWPROT = 3'b000;
    assign S_ARPROT = 3'b000;

    // Channel handshake signals for the granted master and the bridge, per state.
    always_comb begin
        S_AWVALID = 1'b0;
        S_WVALID  = 1'b0;
        S_BREADY  = 1'b0;
        S_ARVALID = 1'b0;
        S_RREADY  = 1'b0;
        aw_rdy    = 1'b0;
        w_rdy     = 1'b0;
        ar_rdy    = 1'b0;
        b_valid   = 1'b0;
        b_resp    = RESP_OKAY;
        r_valid   = 1'b0;
        r_resp    = RESP_OKAY;
        r_data    = '0;
        case (state_q)
            ST_WR_ADDR: begin
                S_AWVALID = g_awvalid & ~aw_done_q;
                aw_rdy    = S_AWREADY & ~aw_done_q;
                S_WVALID  = g_wvalid & ~w_done_q;
                w_rdy     = S_WREADY & ~w_done_q;
            end
            ST_WR_RESP: begin
                S_BREADY = g_bready;
                b_valid  = S_BVALID;
                b_resp   = S_BRESP;
            end
            ST_RD_ADDR: begin
                S_ARVALID = g_arvalid;
                ar_rdy    = S_ARREADY;
            end
            ST_RD_DATA: begin
                S_RREADY = g_rready;
                r_valid  = S_RVALID;
                r_resp   = S_RRESP;
                r_data   = S_RDATA;
            end
            ST_ERR_WR: begin
                aw_rdy = ~aw_done_q;
                w_rdy  = ~w_done_q;
            end
            ST_ERR_RESP: begin
                if (gnt_wr_q) begin
                    b_valid = 1'b1;
                    b_resp  = RESP_DECERR;
                end else if (!ar_done_q) begin
                    ar_rdy = 1'b1;
                end else begin
                    r_valid = 1'b1;
                    r_resp  = RESP_DECERR;
                end
            end
            default: ;
        endcase
    end

    assign M0_AWREADY = aw_rdy  & ~gnt_m_q;
    assign M0_WREADY  = w_rdy   & ~gnt_m_q;
    assign M0_BVALID  = b_valid & ~gnt_m_q;
    assign M0_BRESP   = b_resp  & {2{~gnt_m_q}};
    assign M0_ARREADY = ar_rdy  & ~gnt_m_q;
    assign M0_RVALID  = r_valid & ~gnt_m_q;
    assign M0_RRESP   = r_resp  & {2{~gnt_m_q}};
    assign M0_RDATA   = r_data  & {DATA_W{~gnt_m_q}};
    assign M1_AWREADY = aw_rdy  & gnt_m_q;
    assign M1_WREADY  = w_rdy   & gnt_m_q;
    assign M1_BVALID  = b_valid & gnt_m_q;
    assign M1_BRESP   = b_resp  & {2{gnt_m_q}};
    assign M1_ARREADY = ar_rdy  & gnt_m_q;
    assign M1_RVALID  = r_valid & gnt_m_q;
    assign M1_RRESP   = r_resp  & {2{gnt_m_q}};
    assign M1_RDATA   = r_data  & {DATA_W{gnt_m_q}};

    // Transaction sequencing; every return to IDLE hands priority to the other master.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_m_d   = gnt_m_q;
        gnt_wr_d  = gnt_wr_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        ar_done_d = ar_done_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    gnt_m_d   = pick_m;
                    gnt_wr_d  = pick_wr;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    ar_done_d = 1'b0;
                    if (pick_wr) begin
                        state_d = pick_hit ? ST_WR_ADDR : ST_ERR_WR;
                    end else begin
                        state_d = pick_hit ? ST_RD_ADDR : ST_ERR_RESP;
                    end
                end
            end
            ST_WR_ADDR, ST_ERR_WR: begin
                aw_done_d = aw_done_q | (g_awvalid & aw_rdy);
                w_done_d  = w_done_q  | (g_wvalid & w_rdy);
                if (aw_done_d && w_done_d) begin
                    state_d = (state_q == ST_WR_ADDR) ? ST_WR_RESP : ST_ERR_RESP;
                end
            end
            ST_WR_RESP: if (b_valid && g_bready) state_d = ST_IDLE;
            ST_RD_ADDR: if (g_arvalid && ar_rdy) state_d = ST_RD_DATA;
            ST_RD_DATA: if (r_valid && g_rready) state_d = ST_IDLE;
            ST_ERR_RESP: begin
                if (g_arvalid && ar_rdy) ar_done_d = 1'b1;
                if ((b_valid && g_bready) || (r_valid && g_rready)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_q != ST_IDLE && state_d == ST_IDLE) begin
            rr_ptr_d = ~gnt_m_q;
        end
    end

    // State registers; reset abandons any transaction in flight.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= 1'b0;
            gnt_m_q   <= 1'b0;
            gnt_wr_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            ar_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            gnt_m_q   <= gnt_m_d;
            gnt_wr_q  <= gnt_wr_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            ar_done_q <= ar_done_d;
        end
    end

endmodule

// File: tb/tb_axil_arbiter_2m.sv
// tb/tb_axil_arbiter_2m.sv - directed self-checking bench for axil_arbiter_2m
`define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin failures++; $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); end end
`define WAIT_UNTIL(cond, tag) begin int w_; w_ = 0; while (!(cond) && w_ < 40) begin @(negedge ACLK); #1; w_++; end checks++; if (!(cond)) begin failures++; $error("TIMEOUT %s after %0d cycles", tag, w_); end end

module tb_axil_arbiter_2m;

    logic        ACLK, ARESET;
    logic [31:0] M0_AWADDR, M0_WDATA, M0_ARADDR, M0_RDATA;
    logic        M0_AWVALID, M0_AWREADY, M0_WVALID, M0_WREADY, M0_BVALID, M0_BREADY;
    logic        M0_ARVALID, M0_ARREADY, M0_RVALID, M0_RREADY;
    logic [1:0]  M0_BRESP, M0_RRESP;
    logic [31:0] M1_AWADDR, M1_WDATA, M1_ARADDR, M1_RDATA;
    logic        M1_AWVALID, M1_AWREADY, M1_WVALID, M1_WREADY, M1_BVALID, M1_BREADY;
    logic        M1_ARVALID, M1_ARREADY, M1_RVALID, M1_RREADY;
    logic [1:0]  M1_BRESP, M1_RRESP;
    logic [31:0] S_AWADDR, S_WDATA, S_ARADDR, S_RDATA;
    logic [2:0]  S_AWPROT, S_ARPROT;
    logic        S_AWVALID, S_AWREADY, S_WVALID, S_WREADY, S_BVALID, S_BREADY;
    logic        S_ARVALID, S_ARREADY, S_RVALID, S_RREADY;
    logic [1:0]  S_BRESP, S_RRESP;

    int checks = 0;
    int failures = 0;

    logic [14:0] all_vr;
    logic [4:0]  m0_vr;
    logic [4:0]  m1_vr;
    assign m0_vr  = {M0_AWREADY, M0_WREADY, M0_BVALID, M0_ARREADY, M0_RVALID};
    assign m1_vr  = {M1_AWREADY, M1_WREADY, M1_BVALID, M1_ARREADY, M1_RVALID};
    assign all_vr = {m0_vr, m1_vr,
                     S_AWVALID, S_WVALID, S_BREADY, S_ARVALID, S_RREADY};

    axil_arbiter_2m #(.ADDR_W(32), .DATA_W(32), .BASE_HI(16'h4000)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .M0_AWADDR(M0_AWADDR), .M0_AWVALID(M0_AWVALID), .M0_AWREADY(M0_AWREADY),
        .M0_WDATA(M0_WDATA), .M0_WVALID(M0_WVALID), .M0_WREADY(M0_WREADY),
        .M0_BRESP(M0_BRESP), .M0_BVALID(M0_BVALID), .M0_BREADY(M0_BREADY),
        .M0_ARADDR(M0_ARADDR), .M0_ARVALID(M0_ARVALID), .M0_ARREADY(M0_ARREADY),
        .M0_RDATA(M0_RDATA), .M0_RRESP(M0_RRESP), .M0_RVALID(M0_RVALID), .M0_RREADY(M0_RREADY),
        .M1_AWADDR(M1_AWADDR), .M1_AWVALID(M1_AWVALID), .M1_AWREADY(M1_AWREADY),
        .M1_WDATA(M1_WDATA), .M1_WVALID(M1_WVALID), .M1_WREADY(M1_WREADY),
        .M1_BRESP(M1_BRESP), .M1_BVALID(M1_BVALID), .M1_BREADY(M1_BREADY),
        .M1_ARADDR(M1_ARADDR), .M1_ARVALID(M1_ARVALID), .M1_ARREADY(M1_ARREADY),
        .M1_RDATA(M1_RDATA), .M1_RRESP(M1_RRESP), .M1_RVALID(M1_RVALID), .M1_RREADY(M1_RREADY),
        .S_AWADDR(S_AWADDR), .S_AWPROT(S_AWPROT), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
        .S_WDATA(S_WDATA), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
        .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
        .S_ARADDR(S_ARADDR), .S_ARPROT(S_ARPROT), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
        .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    always @(negedge ACLK) begin
        #2;
        checks++;
        if ({S_AWPROT, S_ARPROT} !== 6'd0 || ((|m0_vr) & (|m1_vr)) !== 1'b0) begin
            failures++;
            $error("FAIL monitor prot=%0h m0_vr=%0h m1_vr=%0h", {S_AWPROT, S_ARPROT}, m0_vr, m1_vr);
        end
    end

    task automatic nxt();
        @(negedge ACLK);
        #1;
    endtask

    task automatic serve_read(input int m, input logic [31:0] addr, input logic [31:0] data);
        `WAIT_UNTIL(S_ARVALID === 1'b1, "rd_s_arvalid")
        `CHK("rd_s_araddr", S_ARADDR, addr)
        `CHK("rd_m0_arready", M0_ARREADY, (m == 0))
        `CHK("rd_m1_arready", M1_ARREADY, (m == 1))
        nxt();
        if (m == 0) M0_ARVALID = 1'b0; else M1_ARVALID = 1'b0;
        S_RDATA  = data;
        S_RRESP  = 2'b00;
        S_RVALID = 1'b1;
        #1;
        `CHK("rd_s_arvalid_off", S_ARVALID, 1'b0)
        `CHK("rd_m0_rvalid", M0_RVALID, (m == 0))
        `CHK("rd_m1_rvalid", M1_RVALID, (m == 1))
        `CHK("rd_rdata", ((m == 0) ? M0_RDATA : M1_RDATA), data)
        nxt();
        S_RVALID = 1'b0;
        #1;
    endtask

    initial begin
        ARESET = 1'b1;
        M0_AWADDR = '0; M0_AWVALID = 0; M0_WDATA = '0; M0_WVALID = 0; M0_BREADY = 1;
        M0_ARADDR = '0; M0_ARVALID = 0; M0_RREADY = 1;
        M1_AWADDR = '0; M1_AWVALID = 0; M1_WDATA = '0; M1_WVALID = 0; M1_BREADY = 1;
        M1_ARADDR = '0; M1_ARVALID = 0; M1_RREADY = 1;
        S_AWREADY = 1; S_WREADY = 1; S_ARREADY = 1;
        S_BRESP = 2'b00; S_BVALID = 0; S_RDATA = '0; S_RRESP = 2'b00; S_RVALID = 0;

        nxt();
        nxt();
        checks++;
        if (all_vr !== 15'd0 || M0_RDATA !== 32'd0 || M1_RDATA !== 32'd0 ||
            {M0_BRESP, M0_RRESP, M1_BRESP, M1_RRESP} !== 8'd0) begin
            failures++;
            $error("FAIL rst_state vr=%0h m0_rdata=%0h m1_rdata=%0h resps=%0h",
                   all_vr, M0_RDATA, M1_RDATA, {M0_BRESP, M0_RRESP, M1_BRESP, M1_RRESP});
        end
        `CHK("rst_valid_ready", all_vr, 15'd0)
        `CHK("rst_m0_rdata", M0_RDATA, 32'd0)
        `CHK("rst_resps", {M0_BRESP, M0_RRESP, M1_BRESP, M1_RRESP}, 8'd0)
        `CHK("rst_prot", {S_AWPROT, S_ARPROT}, 6'd0)
        ARESET = 1'b0;

        nxt();
        M0_ARADDR = 32'h4000_0004; M1_ARADDR = 32'h4000_0004;
        M0_ARVALID = 1; M1_ARVALID = 1;
        serve_read(0, 32'h4000_0004, 32'h0000_00A0);
        serve_read(1, 32'h4000_0004, 32'h0000_00A1);
        nxt();
        M0_ARVALID = 1; M1_ARVALID = 1;
        serve_read(0, 32'h4000_0004, 32'h0000_00A2);
        serve_read(1, 32'h4000_0004, 32'h0000_00A3);

        nxt();
        M0_AWADDR = 32'h4000_0010; M0_WDATA = 32'h1234_5678;
        M0_AWVALID = 1; M0_WVALID = 1;
        #1;
        `CHK("wr0_latency_idle", S_AWVALID, 1'b0)
        nxt();
        `CHK("wr0_s_awvalid", S_AWVALID, 1'b1)
        `CHK("wr0_s_awaddr", S_AWADDR, 32'h4000_0010)
        `CHK("wr0_s_wvalid", S_WVALID, 1'b1)
        `CHK("wr0_s_wdata", S_WDATA, 32'h1234_5678)
        `CHK("wr0_m0_readys", {M0_AWREADY, M0_WREADY}, 2'b11)
        `CHK("wr0_m1_quiet_a", m1_vr, 5'd0)
        nxt();
        M0_AWVALID = 0; M0_WVALID = 0;
        #1;
        `CHK("wr0_s_awvalid_off", S_AWVALID, 1'b0)
        `CHK("wr0_s_bready", S_BREADY, 1'b1)
        S_BVALID = 1; S_BRESP = 2'b00;
        #1;
        `CHK("wr0_m0_bvalid", M0_BVALID, 1'b1)
        `CHK("wr0_m0_bresp", M0_BRESP, 2'b00)
        `CHK("wr0_m1_quiet_b", m1_vr, 5'd0)
        nxt();
        S_BVALID = 0;
        #1;
        `CHK("wr0_m0_bvalid_off", M0_BVALID, 1'b0)

        S_AWREADY = 0;
        nxt();
        M1_AWADDR = 32'h4000_0020; M1_WDATA = 32'hCAFE_0001; M1_WVALID = 1;
        nxt();
        `CHK("wr1_s_wvalid", S_WVALID, 1'b1)
        `CHK("wr1_m1_wready", M1_WREADY, 1'b1)
        `CHK("wr1_m1_awready_early", M1_AWREADY, 1'b0)
        `CHK("wr1_s_awvalid_early", S_AWVALID, 1'b0)
        nxt();
        M1_WVALID = 0;
        #1;
        `CHK("wr1_wready_done", {M1_WREADY, S_WVALID}, 2'b00)
        nxt();
        nxt();
        M1_AWVALID = 1; S_AWREADY = 1;
        #1;
        `CHK("wr1_s_awvalid", S_AWVALID, 1'b1)
        `CHK("wr1_m1_awready", M1_AWREADY, 1'b1)
        `CHK("wr1_no_second_w", S_WVALID, 1'b0)
        nxt();
        M1_AWVALID = 0;
        S_BVALID = 1; S_BRESP = 2'b00;
        #1;
        `CHK("wr1_s_awvalid_off", S_AWVALID, 1'b0)
        `CHK("wr1_m1_bvalid", M1_BVALID, 1'b1)
        `CHK("wr1_m0_bvalid", M0_BVALID, 1'b0)
        nxt();
        S_BVALID = 0;
        #1;
        `CHK("wr1_b_once", M1_BVALID, 1'b0)

        nxt();
        M0_ARADDR = 32'h5000_0000; M0_ARVALID = 1;
        nxt();
        `CHK("dec_m0_arready", M0_ARREADY, 1'b1)
        `CHK("dec_no_s_ar_a", S_ARVALID, 1'b0)
        `CHK("dec_rvalid_early", M0_RVALID, 1'b0)
        nxt();
        M0_ARVALID = 0;
        #1;
        `CHK("dec_m0_rvalid", M0_RVALID, 1'b1)
        `CHK("dec_m0_rresp", M0_RRESP, 2'b11)
        `CHK("dec_m0_rdata", M0_RDATA, 32'd0)
        `CHK("dec_no_s_ar_b", S_ARVALID, 1'b0)
        `CHK("dec_m1_quiet", m1_vr, 5'd0)
        nxt();
        `CHK("dec_done", {M0_RVALID, S_ARVALID}, 2'b00)

        nxt();
        M1_AWADDR = 32'h4000_0030; M1_WDATA = 32'h0000_BEEF;
        M1_AWVALID = 1; M1_WVALID = 1;
        nxt();
        `CHK("slv_s_awaddr", S_AWADDR, 32'h4000_0030)
        `CHK("slv_m_awready", {M1_AWREADY, M0_AWREADY}, 2'b10)
        nxt();
        M1_AWVALID = 0; M1_WVALID = 0;
        S_BVALID = 1; S_BRESP = 2'b10;
        M0_ARADDR = 32'h4000_0008; M0_ARVALID = 1;
        #1;
        `CHK("slv_m1_bvalid", M1_BVALID, 1'b1)
        `CHK("slv_m1_bresp", M1_BRESP, 2'b10)
        `CHK("slv_m0_bvalid", M0_BVALID, 1'b0)
        nxt();
        S_BVALID = 0; S_BRESP = 2'b00;
        #1;
        `CHK("slv_m1_bvalid_off", M1_BVALID, 1'b0)
        serve_read(0, 32'h4000_0008, 32'h0000_00B5);

        nxt();
        M0_AWADDR = 32'h4000_0040; M0_WDATA = 32'h0000_0040;
        M0_AWVALID = 1; M0_WVALID = 1;
        nxt();
        `CHK("rstm_s_awvalid", S_AWVALID, 1'b1)
        nxt();
        M0_AWVALID = 0; M0_WVALID = 0;
        #1;
        `CHK("rstm_in_wr_resp", {S_BREADY, M0_BVALID}, 2'b10)
        ARESET = 1'b1;
        nxt();
        `CHK("rstm_all_quiet", all_vr, 15'd0)
        `CHK("rstm_resps", {M0_BRESP, M1_BRESP}, 4'd0)
        ARESET = 1'b0;
        M1_ARADDR = 32'h4000_000C; M1_ARVALID = 1;
        serve_read(1, 32'h4000_000C, 32'h0000_00C6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
